branch_resolve: RTL and testbench



---
 rtl/branch_resolve.sv | 143 ++++++++++++++
 tb/tb_branch_resolve.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Two-stage branch resolution unit: S1 latches compare flags and both candidate
// addresses, S2 evaluates the condition and holds taken/target behind a valid/ready
// output handshake. Also keeps a saturating count of delivered taken branches.
module branch_resolve #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cond,
  input  logic              is_signed,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       offset,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic [CNT_W-1:0]  taken_count
);

  // Offset extension width: wide enough for the 18-bit shifted offset and the PC.
  localparam int unsigned ExtW = (ADDR_W > 18) ? ADDR_W : 18;

  logic              s1_valid_q, s1_valid_d;
  logic [1:0]        flags_q, flags_d;
  logic [2:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] seq_q, seq_d;
  logic [ADDR_W-1:0] br_q, br_d;
  logic              s2_valid_q, s2_valid_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_adv, s1_adv, accept, fire, cond_met;
  logic [WIDTH-1:0]  a_cmp, b_cmp;
  logic signed [ExtW-1:0] off_ext;

  // Pipeline advance terms; in_ready depends only on state and out_ready.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    accept = in_valid && s1_adv && !flush;
    fire   = s2_valid_q && out_ready;
  end

  assign in_ready    = s1_adv;
  assign out_valid   = s2_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign taken_count = cnt_q;

  // S1 next state: flipping the MSBs turns a signed compare into an unsigned one.
  always_comb begin
    a_cmp              = op_a;
    b_cmp              = op_b;
    a_cmp[WIDTH-1]     = op_a[WIDTH-1] ^ is_signed;
    b_cmp[WIDTH-1]     = op_b[WIDTH-1] ^ is_signed;
    off_ext            = ExtW'($signed({offset, 2'b00}));
    s1_valid_d         = s1_valid_q;
    flags_d            = flags_q;
    cond_d             = cond_q;
    seq_d              = seq_q;
    br_d               = br_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      flags_d = {a_cmp < b_cmp, a_cmp > b_cmp};
      cond_d  = cond;
      seq_d   = pc + ADDR_W'(4);
      br_d    = pc + ADDR_W'(4) + off_ext[ADDR_W-1:0];
    end
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      3'b000:  cond_met = (flags_q == 2'b00);
      3'b001:  cond_met = (flags_q != 2'b00);
      3'b010:  cond_met = !flags_q[1];
      3'b011:  cond_met = !flags_q[0];
      3'b100:  cond_met = (flags_q == 2'b01);
      3'b101:  cond_met = (flags_q == 2'b10);
      3'b110:  cond_met = 1'b0;
      default: cond_met = 1'b1;
    endcase
  end

  // S2 next state and taken counter; a result handshaken during flush still counts.
  always_comb begin
    s2_valid_d = s2_valid_q;
    taken_d    = taken_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q && !flush) begin
      taken_d  = cond_met;
      target_d = cond_met ? br_q : seq_q;
    end
    if (fire && taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      flags_q    <= 2'b00;
      cond_q     <= 3'b000;
      seq_q      <= '0;
      br_q       <= '0;
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      flags_q    <= flags_d;
      cond_q     <= cond_d;
      seq_q      <= seq_d;
      br_q       <= br_d;
      s2_valid_q <= s2_valid_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-written multi-cycle sequences
// and a randomized phase, all compared against a queue-based reference model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, is_signed, flush, out_ready;
  logic [2:0]  cond;
  logic [31:0] op_a, op_b, pc;
  logic [15:0] offset;

  logic        in_ready, out_valid, taken;
  logic [31:0] target;
  logic [15:0] taken_count;
  logic        in_ready2, out_valid2, taken2;
  logic [31:0] target2;
  logic [1:0]  taken_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve #(.WIDTH(32), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cond(cond),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .pc(pc), .offset(offset),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .taken_count(taken_count)
  );

  branch_resolve #(.WIDTH(32), .ADDR_W(32), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .cond(cond),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .pc(pc), .offset(offset),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .taken(taken2),
    .target(target2), .taken_count(taken_count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on 64-bit integers.
  function automatic void ref_result(input logic [2:0] c, input logic s,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] p, input logic [15:0] o,
                                     output logic t, output logic [31:0] tg);
    longint av, bv, off;
    if (s) begin
      av = $signed(a);
      bv = $signed(b);
    end else begin
      av = longint'(a);
      bv = longint'(b);
    end
    case (c)
      3'd0:    t = (av == bv);
      3'd1:    t = (av != bv);
      3'd2:    t = (av >= bv);
      3'd3:    t = (av <= bv);
      3'd4:    t = (av > bv);
      3'd5:    t = (av < bv);
      3'd6:    t = 1'b0;
      default: t = 1'b1;
    endcase
    off = $signed(o);
    tg  = 32'(longint'(p) + 4 + (t ? off * 4 : 0));
  endfunction

  typedef struct {
    logic        t;
    logic [31:0] tg;
    int          stage;
  } item_t;

  item_t mq[$];
  int    mcount = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference model: in-flight queue, head is visible once it reaches stage 2.
  initial begin
    logic  ov, ir, t;
    logic [31:0] tg;
    item_t it;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mcount = 0;
      end else begin
        ov = (mq.size() > 0) && (mq[0].stage == 2);
        ir = (mq.size() < 2) || out_ready;
        if (ov && out_ready && mq[0].t) mcount++;
        if (flush) begin
          mq.delete();
        end else begin
          if (ov && out_ready) void'(mq.pop_front());
          if (mq.size() > 0) mq[0].stage = 2;
          if (in_valid && ir) begin
            ref_result(cond, is_signed, op_a, op_b, pc, offset, t, tg);
            it.t = t;
            it.tg = tg;
            it.stage = 1;
            mq.push_back(it);
          end
        end
      end
    end
  end

  // Cycle monitor: compare every output with the model mid-cycle.
  initial begin
    logic ov_exp;
    forever begin
      @(negedge clk);
      ov_exp = (mq.size() > 0) && (mq[0].stage == 2);
      check("mon_out_valid", 64'(out_valid), 64'(ov_exp));
      check("mon_out_valid_c2", 64'(out_valid2), 64'(ov_exp));
      check("mon_in_ready", 64'(in_ready), 64'((mq.size() < 2) || out_ready));
      check("mon_count", 64'(taken_count), 64'(sat(mcount, 65535)));
      check("mon_count_c2", 64'(taken_count2), 64'(sat(mcount, 3)));
      if (ov_exp) begin
        check("mon_taken", 64'(taken), 64'(mq[0].t));
        check("mon_target", 64'(target), 64'(mq[0].tg));
      end
    end
  end

  typedef struct {
    logic [2:0]  c;
    logic        s;
    logic [31:0] a, b, p;
    logic [15:0] o;
    logic        et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [15:0] o);
    cond = c; is_signed = s; op_a = a; op_b = b; pc = p; offset = o;
  endtask

  task automatic apply_vec(input int i);
    set_req(vecs[i].c, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
    check($sformatf("vec%0d_taken", i), 64'(taken), 64'(vecs[i].et));
    check($sformatf("vec%0d_target", i), 64'(target), 64'(vecs[i].etg));
    tick();
  endtask

  initial begin
    int idx, cyc, snap;
    logic got;
    vecs[0]  = '{3'd0, 1'b0, 32'd5, 32'd5, 32'h100, 16'h0003, 1'b1, 32'h110};
    vecs[1]  = '{3'd5, 1'b1, 32'hFFFFFFFF, 32'd1, 32'h200, 16'h0010, 1'b1, 32'h244};
    vecs[2]  = '{3'd5, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h200, 16'h0010, 1'b0, 32'h204};
    vecs[3]  = '{3'd1, 1'b0, 32'd3, 32'd3, 32'h300, 16'h0001, 1'b0, 32'h304};
    vecs[4]  = '{3'd2, 1'b1, 32'h80000000, 32'd0, 32'h400, 16'h0002, 1'b0, 32'h404};
    vecs[5]  = '{3'd2, 1'b0, 32'h80000000, 32'd0, 32'h400, 16'h0002, 1'b1, 32'h40C};
    vecs[6]  = '{3'd3, 1'b0, 32'd7, 32'd7, 32'h500, 16'hFFFE, 1'b1, 32'h4FC};
    vecs[7]  = '{3'd4, 1'b1, 32'd1, 32'hFFFFFFFF, 32'h600, 16'h0000, 1'b1, 32'h604};
    vecs[8]  = '{3'd6, 1'b0, 32'd5, 32'd5, 32'h700, 16'h0001, 1'b0, 32'h704};
    vecs[9]  = '{3'd7, 1'b0, 32'd0, 32'd9, 32'hFFFFFFFC, 16'hFFFF, 1'b1, 32'hFFFFFFFC};
    vecs[10] = '{3'd5, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h800, 16'h0004, 1'b1, 32'h814};
    vecs[11] = '{3'd4, 1'b0, 32'd0, 32'd1, 32'h900, 16'h0000, 1'b0, 32'h904};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_req(3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_taken", 64'(taken), 64'd0);
    check("rst_target", 64'(target), 64'd0);
    check("rst_count", 64'(taken_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Directed vector table: seven taken results from reset.
    for (int i = 0; i < 12; i++) begin
      apply_vec(i);
      if (i == 0) check("first_count", 64'(taken_count), 64'd1);
    end
    check("table_count", 64'(taken_count), 64'd7);
    check("table_count_sat2", 64'(taken_count2), 64'd3);

    // Back-to-back stream, out_ready pattern 1,0,0,1 repeating.
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      set_req(3'(idx), 1'b0, 32'(idx), 32'd3, 32'h1000 + 32'(16 * idx), 16'(idx));
      in_valid = 1'b1;
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) idx++;
      cyc++;
    end
    check("stream_all_accepted", 64'(idx), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Flush with both stages full and out_ready low: nothing delivered.
    snap = mcount;
    out_ready = 1'b0;
    set_req(3'd7, 1'b0, 32'd0, 32'd0, 32'h2000, 16'd1);
    in_valid = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("flush_full_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flush_no_result", 64'(out_valid), 64'd0);
    end
    check("flush_count", 64'(taken_count), 64'(sat(snap, 65535)));

    // Flush while the head is handshaken and a new input is offered.
    snap = mcount;
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("flush_hs_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_hs_out_valid", 64'(out_valid), 64'd0);
    check("flush_hs_count", 64'(taken_count), 64'(sat(snap + 1, 65535)));
    tick();
    tick();
    check("flush_hs_no_result", 64'(out_valid), 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      op_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      op_a = ($urandom_range(0, 3) == 0) ? op_b :
             (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      cond = 3'($urandom_range(0, 7));
      is_signed = 1'($urandom_range(0, 1));
      pc = $urandom;
      offset = 16'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset between edges while results are streaming.
    set_req(3'd7, 1'b0, 32'd0, 32'd0, 32'h3000, 16'd2);
    in_valid = 1'b1;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(taken_count), 64'd0);
    check("arst_count_c2", 64'(taken_count2), 64'd0);
    check("arst_taken", 64'(taken), 64'd0);
    check("arst_target", 64'(target), 64'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    apply_vec(0);
    check("resume_count1", 64'(taken_count), 64'd1);
    apply_vec(9);
    check("resume_count2", 64'(taken_count), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
